// File: rtl/mips_pkg.sv
// Shared MIPS core encodings: ALU opcodes, HI/LO operations and branch kinds.
package mips_pkg;

  // ALU opcodes, shared with the ALU and the decoder
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_MULU = 4'd3;
  localparam logic [3:0] ALU_DIVU = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;

  // HI/LO operation carried by the instruction; unlisted codes mean none
  typedef enum logic [2:0] {
    HILO_NONE   = 3'b000,
    HILO_MFHI   = 3'b001,
    HILO_MFLO   = 3'b010,
    HILO_MTHI   = 3'b011,
    HILO_MTLO   = 3'b100,
    HILO_MULDIV = 3'b101
  } hilo_op_e;

  // Conditional branch kind; 2'b11 is reserved and behaves as none
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } br_kind_e;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_regs
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Reset clears both registers and overrides any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (we_hi) hi <= hi_d;
      if (we_lo) lo <= lo_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results and control, owns HI/LO,
// and resolves beq/bne into a one-cycle fetch redirect.
module ex_mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_aluop,
  input  logic [31:0] ex_res1,
  input  logic [31:0] ex_res2,
  input  logic        ex_equ,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [1:0]  ex_branch,
  input  logic [31:0] ex_branch_target,
  input  logic [2:0]  ex_hilo_op,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_valid,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic [31:0] mem_rt_data,
  output logic [4:0]  mem_wreg,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic        cap;
  logic        taken;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic [31:0] result_next;

  assign cap   = ex_valid & ~stall & ~flush;
  assign taken = cap & (((ex_branch == BR_EQ) & ex_equ) |
                        ((ex_branch == BR_NE) & ~ex_equ));

  // HI/LO write decode; a divide by zero leaves both untouched since the
  // ALU outputs are meaningless in that case
  always_comb begin
    we_hi = 1'b0;
    we_lo = 1'b0;
    hi_d  = ex_res1;
    lo_d  = ex_res1;
    if (cap) begin
      case (ex_hilo_op)
        HILO_MTHI: we_hi = 1'b1;
        HILO_MTLO: we_lo = 1'b1;
        HILO_MULDIV: begin
          if ((ex_aluop == ALU_MULU) ||
              ((ex_aluop == ALU_DIVU) && (ex_rt_data != 32'd0))) begin
            we_hi = 1'b1;
            we_lo = 1'b1;
            hi_d  = ex_res2;
          end
        end
        default: ;
      endcase
    end
  end

  // Result select: mfhi/mflo read the registered HI/LO, so a commit one
  // cycle earlier is already visible without a bypass
  always_comb begin
    case (ex_hilo_op)
      HILO_MFHI: result_next = hi;
      HILO_MFLO: result_next = lo;
      default:   result_next = ex_res1;
    endcase
  end

  hilo_regs u_hilo_regs (
    .clk   (clk),
    .rst   (rst),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .hi_d  (hi_d),
    .lo_d  (lo_d),
    .hi    (hi),
    .lo    (lo)
  );

  // Pipeline register: reset > flush > stall > capture > bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_pc       <= 32'd0;
      mem_result   <= 32'd0;
      mem_rt_data  <= 32'd0;
      mem_wreg     <= 5'd0;
      redirect     <= 1'b0;
      redirect_pc  <= 32'd0;
    end else if (flush) begin
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_pc       <= 32'd0;
      mem_result   <= 32'd0;
      mem_rt_data  <= 32'd0;
      mem_wreg     <= 5'd0;
      redirect     <= 1'b0;
      redirect_pc  <= 32'd0;
    end else if (stall) begin
      // contents hold; only the redirect pulse is dropped so it cannot repeat
      redirect <= 1'b0;
    end else if (ex_valid) begin
      mem_valid    <= 1'b1;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_pc       <= ex_pc;
      mem_result   <= result_next;
      mem_rt_data  <= ex_rt_data;
      mem_wreg     <= ex_wreg;
      redirect     <= taken;
      if (taken) redirect_pc <= ex_branch_target;
    end else begin
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_pc       <= 32'd0;
      mem_result   <= 32'd0;
      mem_rt_data  <= 32'd0;
      mem_wreg     <= 5'd0;
      redirect     <= 1'b0;
    end
  end

endmodule
